// File: rtl/score_renderer.sv
// Purpose: draws the last DEPTH accepted notes left-to-right on a five-line staff over generated VGA timing.
// Latency: 2 clk from the timing counters to vga_rgb, hsync, vsync and frame_start.
// Backpressure: note_ready is low while a note is pending; at most one note is committed per frame.
module score_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DEPTH    = 16,
    parameter int SLOT_W   = 32,
    parameter int STAFF_Y  = 200,
    parameter int LINE_GAP = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     note_valid,
    input  logic [7:0]               note,
    input  logic [3:0]               duration,
    output logic                     note_ready,
    input  logic                     clear,
    output logic                     hsync,
    output logic                     vsync,
    output logic [2:0]               vga_rgb,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(SLOT_W);
    localparam int KW = HW - XW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [11:0] YBOT     = 12'(STAFF_Y + 4 * LINE_GAP);
    localparam logic signed [11:0] HALF_GAP = 12'(LINE_GAP / 2);
    localparam logic signed [11:0] VMAX     = 12'(V_ACTIVE);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          active_raw, hs_raw, vs_raw, fs_raw;

    logic [AW-1:0] head, tail, head_n, tail_n, disp_tail, rd_addr;
    logic [CW-1:0] wcount, wcount_n, disp_count;
    logic          pend_vld, do_commit;
    logic [11:0]   pend_dat;
    logic [11:0]   ring [DEPTH];
    logic [11:0]   rd_dat;
    logic [KW-1:0] slot;

    logic          act_q, show_q, new_q, hs_q, vs_q, fs_q;
    logic [XW-1:0] xo_q;
    logic [VW-1:0] y_q;

    logic [3:0]          letter, dur;
    logic [2:0]          octave;
    logic                sharp, is_note, is_rest, yc_ok, hollow;
    logic                dy_in2, dy_in1, head_px, stem_px, flag_px, sharp_px, rest_px;
    logic                glyph, staff;
    logic [6:0]          step;
    logic signed [11:0]  yc;
    logic signed [12:0]  dy;
    logic [15:0]         xo_w;
    logic [31:0]         y_w;
    logic [2:0]          rgb_n;

    assign active_raw = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));
    assign hs_raw = !((hcount >= HW'(H_ACTIVE + H_FP)) && (hcount < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw = !((vcount >= VW'(V_ACTIVE + V_FP)) && (vcount < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign fs_raw = (hcount == '0) && (vcount == VW'(V_ACTIVE));

    assign note_ready = !pend_vld && !reset;
    assign do_commit  = fs_raw && pend_vld;
    assign count      = disp_count;

    // Raster position counters; the line counter steps when the pixel counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == HW'(H_TOTAL - 1)) begin
            hcount <= '0;
            vcount <= (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    // Write-side ring bookkeeping: clear first, then the frame-boundary commit on top of it.
    always_comb begin
        head_n   = head;
        tail_n   = tail;
        wcount_n = wcount;
        if (clear) begin
            tail_n   = head;
            wcount_n = '0;
        end
        if (do_commit) begin
            head_n = head + AW'(1);
            if (wcount_n == CW'(DEPTH)) begin
                tail_n = tail_n + AW'(1);
            end else begin
                wcount_n = wcount_n + CW'(1);
            end
        end
    end

    // Pending note register, ring pointers, and the display snapshot taken at start of vblank.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            wcount     <= '0;
            disp_tail  <= '0;
            disp_count <= '0;
            pend_vld   <= 1'b0;
            pend_dat   <= '0;
        end else begin
            head   <= head_n;
            tail   <= tail_n;
            wcount <= wcount_n;
            if (fs_raw) begin
                disp_tail  <= tail_n;
                disp_count <= wcount_n;
            end
            if (do_commit) begin
                pend_vld <= 1'b0;
            end
            if (note_valid && note_ready) begin
                pend_vld <= 1'b1;
                pend_dat <= {note, duration};
            end
        end
    end

    assign slot    = hcount[HW-1:XW];
    assign rd_addr = disp_tail + AW'(slot);

    // Note storage: written once per frame at commit, read one cycle ahead of the pixel decision.
    always_ff @(posedge clk) begin
        if (do_commit) begin
            ring[head] <= pend_dat;
        end
        rd_dat <= ring[rd_addr];
    end

    // Stage 1: register slot occupancy, position within the slot, line and sync timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q  <= 1'b0;
            show_q <= 1'b0;
            new_q  <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            fs_q   <= 1'b0;
            xo_q   <= '0;
            y_q    <= '0;
        end else begin
            act_q  <= active_raw;
            show_q <= active_raw && (32'(slot) < 32'(disp_count));
            new_q  <= (32'(slot) + 32'd1) == 32'(disp_count);
            hs_q   <= hs_raw;
            vs_q   <= vs_raw;
            fs_q   <= fs_raw;
            xo_q   <= hcount[XW-1:0];
            y_q    <= vcount;
        end
    end

    // Stage 2 decision: glyph geometry relative to the note centre line, then staff, then paper.
    always_comb begin
        letter  = rd_dat[11:8];
        octave  = rd_dat[7:5];
        sharp   = rd_dat[4];
        dur     = rd_dat[3:0];
        step    = 7'(octave) * 7'd7 + 7'(letter);
        yc      = YBOT - ($signed({5'b0, step}) - 12'sd30) * HALF_GAP;
        dy      = $signed({1'b0, 12'(y_q)}) - $signed({yc[11], yc});
        xo_w    = 16'(xo_q);
        y_w     = 32'(y_q);
        is_note = letter <= 4'd6;
        is_rest = letter == 4'hF;
        yc_ok   = !yc[11] && (yc < VMAX);
        hollow  = dur[2] || dur[3];
        dy_in2  = (dy >= -13'sd2) && (dy <= 13'sd2);
        dy_in1  = (dy >= -13'sd1) && (dy <= 13'sd1);
        head_px = (xo_w >= 16'd12) && (xo_w <= 16'd19) && dy_in2 &&
                  !(hollow && (xo_w >= 16'd13) && (xo_w <= 16'd18) && dy_in1);
        stem_px = !dur[3] && (xo_w == 16'd19) && (dy >= -13'sd24) && (dy <= -13'sd3);
        flag_px = dur[0] && (xo_w >= 16'd20) && (xo_w <= 16'd22) &&
                  (dy >= -13'sd24) && (dy <= -13'sd22);
        sharp_px = sharp && (xo_w >= 16'd6) && (xo_w <= 16'd8) && dy_in1;
        rest_px = (xo_w >= 16'd12) && (xo_w <= 16'd19) &&
                  (y_w >= 32'(STAFF_Y + LINE_GAP + 2)) && (y_w <= 32'(STAFF_Y + LINE_GAP + 4));
        glyph   = show_q && ((is_note && yc_ok && (head_px || stem_px || flag_px || sharp_px)) ||
                             (is_rest && rest_px));
        staff   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (y_w == 32'(STAFF_Y + i * LINE_GAP)) begin
                staff = 1'b1;
            end
        end
        rgb_n = 3'b111;
        if (!act_q) begin
            rgb_n = 3'b000;
        end else if (glyph) begin
            rgb_n = new_q ? 3'b100 : 3'b000;
        end else if (staff) begin
            rgb_n = 3'b000;
        end
    end

    // Stage 2: output registers, syncs delayed to line up with the pixel colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rgb     <= 3'b000;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_rgb     <= rgb_n;
            hsync       <= hs_q;
            vsync       <= vs_q;
            frame_start <= fs_q;
        end
    end
endmodule

// File: tb/tb_score_renderer.sv
module tb_score_renderer;
    localparam int H_ACTIVE = 128, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 56, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int DEPTH = 4, SLOT_W = 32, STAFF_Y = 12, LINE_GAP = 8;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = HT * VT;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [7:0] note;
        logic [3:0] dur;
    } ent_t;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic [2:0]    rgb;
        logic          fs;
        logic [CW-1:0] cnt;
    } exp_t;

    localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, rgb: 3'b000, fs: 1'b0, cnt: '0};

    logic          clk, reset, note_valid, note_ready, clear;
    logic [7:0]    note;
    logic [3:0]    duration;
    logic          hsync, vsync, frame_start;
    logic [2:0]    vga_rgb;
    logic [CW-1:0] count;

    int   checks = 0;
    int   failures = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;

    int   m_h, m_v;
    logic m_pend;
    ent_t m_pend_e;
    ent_t wq[$];
    ent_t dq[$];
    exp_t s1, s2;
    exp_t expq[$];

    score_renderer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .DEPTH(DEPTH), .SLOT_W(SLOT_W), .STAFF_Y(STAFF_Y), .LINE_GAP(LINE_GAP)
    ) dut (
        .clk(clk), .reset(reset), .note_valid(note_valid), .note(note),
        .duration(duration), .note_ready(note_ready), .clear(clear),
        .hsync(hsync), .vsync(vsync), .vga_rgb(vga_rgb),
        .frame_start(frame_start), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph rules, evaluated directly in pixel coordinates.
    function automatic bit glyph_hit(input ent_t e, input int xo, input int y);
        int letter, oct, yc, dy, ady;
        bit hollow, whole, eighth;
        letter = int'(e.note[7:4]);
        oct    = int'(e.note[3:1]);
        if (letter == 15)
            return xo >= 12 && xo <= 19 && y >= STAFF_Y + LINE_GAP + 2 && y <= STAFF_Y + LINE_GAP + 4;
        if (letter > 6) return 1'b0;
        yc = STAFF_Y + 4 * LINE_GAP - ((oct * 7 + letter) - 30) * LINE_GAP / 2;
        if (yc < 0 || yc >= V_ACTIVE) return 1'b0;
        dy  = y - yc;
        ady = (dy < 0) ? -dy : dy;
        whole  = e.dur == 4'b1000;
        hollow = whole || e.dur == 4'b0100;
        eighth = e.dur == 4'b0001;
        if (xo >= 12 && xo <= 19 && ady <= 2 && !(hollow && xo >= 13 && xo <= 18 && ady <= 1)) return 1'b1;
        if (!whole && xo == 19 && dy >= -24 && dy <= -3) return 1'b1;
        if (eighth && xo >= 20 && xo <= 22 && dy >= -24 && dy <= -22) return 1'b1;
        if (e.note[0] && xo >= 6 && xo <= 8 && ady <= 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] pixel(input int x, input int y);
        int k, xo;
        k  = x / SLOT_W;
        xo = x % SLOT_W;
        if (k < dq.size() && glyph_hit(dq[k], xo, y))
            return (k == dq.size() - 1) ? 3'b100 : 3'b000;
        if (y >= STAFF_Y && y <= STAFF_Y + 4 * LINE_GAP && (y - STAFF_Y) % LINE_GAP == 0)
            return 3'b000;
        return 3'b111;
    endfunction

    function automatic exp_t expect_at(input int h, input int v);
        exp_t e;
        e.hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        e.vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        e.fs  = (h == 0 && v == V_ACTIVE);
        e.rgb = (h < H_ACTIVE && v < V_ACTIVE) ? pixel(h, v) : 3'b000;
        e.cnt = '0;
        return e;
    endfunction

    // Behavioural model: history as a bounded queue, snapshot copied at start of vblank.
    always @(posedge clk) begin : model
        exp_t cur, e;
        bit   acc, fsc;
        if (reset) begin
            m_h = 0; m_v = 0; m_pend = 1'b0;
            wq.delete(); dq.delete();
            s1 = RST_EXP; s2 = RST_EXP;
        end else begin
            fsc = (m_h == 0 && m_v == V_ACTIVE);
            cur = expect_at(m_h, m_v);
            acc = note_valid && !m_pend;
            if (clear) wq.delete();
            if (fsc && m_pend) begin
                if (wq.size() == DEPTH) void'(wq.pop_front());
                wq.push_back(m_pend_e);
                m_pend = 1'b0;
            end
            if (acc) begin
                m_pend   = 1'b1;
                m_pend_e = '{note: note, dur: duration};
            end
            if (fsc) dq = wq;
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            s2 = s1;
            s1 = cur;
        end
        e = s2;
        e.cnt = CW'(dq.size());
        expq.push_back(e);
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e, got;
        logic rdy_exp;
        if (tmo_cnt > tmo_seen) begin
            tmo_seen = tmo_seen + 1;
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL wait_timeout t=%0t got expired_bound required event", $time);
        end
        if (expq.size() != 0) begin
            e   = expq.pop_front();
            got = '{hs: hsync, vs: vsync, rgb: vga_rgb, fs: frame_start, cnt: count};
            checks = checks + 1;
            if (got !== e) begin
                failures = failures + 1;
                $display("FAIL video_out t=%0t got hs=%b vs=%b rgb=%b fs=%b cnt=%0d required hs=%b vs=%b rgb=%b fs=%b cnt=%0d",
                         $time, got.hs, got.vs, got.rgb, got.fs, got.cnt, e.hs, e.vs, e.rgb, e.fs, e.cnt);
            end
            rdy_exp = !m_pend && !reset;
            checks = checks + 1;
            if (note_ready !== rdy_exp) begin
                failures = failures + 1;
                $display("FAIL note_ready t=%0t got %b required %b", $time, note_ready, rdy_exp);
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs();
        int budget;
        budget = 2 * FRAME;
        do begin
            step_clk();
            budget--;
        end while (!(m_h == 0 && m_v == V_ACTIVE) && budget > 0);
        if (budget == 0) tmo_cnt++;
    endtask

    task automatic wait_line(input int line);
        int budget;
        budget = 2 * FRAME;
        do begin
            step_clk();
            budget--;
        end while (!(m_h == 0 && m_v == line) && budget > 0);
        if (budget == 0) tmo_cnt++;
    endtask

    task automatic offer(input logic [7:0] n, input logic [3:0] d, input logic clr, input int max_dly);
        int budget;
        budget = 2 * FRAME;
        while (!note_ready && budget > 0) begin
            step_clk();
            budget--;
        end
        if (budget == 0) tmo_cnt++;
        if (max_dly > 0) repeat ($urandom_range(max_dly)) step_clk();
        note = n; duration = d; clear = clr; note_valid = 1'b1;
        step_clk();
        note_valid = 1'b0; clear = 1'b0;
    endtask

    function automatic logic [7:0] rand_note();
        int r;
        logic [3:0] letter;
        r = int'($urandom_range(9));
        if (r == 7)      letter = 4'hF;
        else if (r == 8) letter = 4'($urandom_range(14, 7));
        else             letter = 4'($urandom_range(6));
        return {letter, 3'($urandom_range(5, 3)), 1'($urandom_range(1))};
    endfunction

    initial begin
        reset = 1'b1; note_valid = 1'b0; note = '0; duration = '0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // E4 quarter, offered mid-frame
        offer(8'h28, 4'b0010, 1'b0, 1500);
        // F4 whole, accepted exactly on a frame_start cycle with nothing pending
        wait_fs();
        wait_fs();
        offer(8'h38, 4'b1000, 1'b0, 0);
        // G4 sharp eighth, then random notes to scroll the ring
        offer(8'h49, 4'b0001, 1'b0, 2000);
        offer(rand_note(), 4'(1 << $urandom_range(3)), 1'b0, 2000);
        offer(rand_note(), 4'(1 << $urandom_range(3)), 1'b0, 2000);
        // clear in the same cycle as an accepted C5 quarter
        offer(8'h0A, 4'b0010, 1'b1, 2000);
        wait_fs();
        wait_line(30);
        reset = 1'b1;
        repeat (4) step_clk();
        reset = 1'b0;
        wait_fs();
        repeat (3 * HT) step_clk();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
